// File: rtl/riscv_alu_cmd_master_pkg.sv
// Shared encodings for the ALU command master, the memory-mapped ALU slave and its bench:
// register offsets, AHB-Lite field encodings, FSM states and ALU opcodes.
package riscv_alu_cmd_master_pkg;

  localparam logic [31:0] OFF_OP = 32'h0000_0000;
  localparam logic [31:0] OFF_A  = 32'h0000_0004;
  localparam logic [31:0] OFF_B  = 32'h0000_0008;
  localparam logic [31:0] OFF_P  = 32'h0000_000C;

  localparam int unsigned W_BURST = 3;

  localparam logic [1:0]         HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]         HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]         HRESP_OKAY    = 2'b00;
  localparam logic [1:0]         HRESP_ERROR   = 2'b01;
  localparam logic [2:0]         HSIZE_WORD    = 3'b010;
  localparam logic [W_BURST-1:0] HBURST_SINGLE = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/riscv_alu_cmd_master.sv
// AHB-Lite master that runs one ALU command as write A, write B, write OP, read P
// against the memory-mapped ALU slave and returns the result on a valid/ready port.
module riscv_alu_cmd_master
  import riscv_alu_cmd_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hE000_0000
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [3:0]         i_cmd_op,
  input  logic [31:0]        i_cmd_a,
  input  logic [31:0]        i_cmd_b,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [31:0]        o_rsp_data,
  output logic               o_rsp_err,
  input  logic [31:0]        i_HRDATA,
  input  logic [1:0]         i_HRESP,
  input  logic               i_HREADY,
  output logic [31:0]        o_HADDR,
  output logic [31:0]        o_HWDATA,
  output logic               o_HWRITE,
  output logic [2:0]         o_HSIZE,
  output logic [W_BURST-1:0] o_HBURST,
  output logic [1:0]         o_HTRANS
);

  // Transfer index order: A, B, OP, then the P read.
  function automatic logic [31:0] xfer_offset(input logic [1:0] xi);
    case (xi)
      2'd0:    return OFF_A;
      2'd1:    return OFF_B;
      2'd2:    return OFF_OP;
      default: return OFF_P;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  xi_q, xi_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        data_err;

  // RETRY and SPLIT are folded into ERROR; the flag stays set across wait states.
  assign data_err = err_q | (i_HRESP != HRESP_OKAY);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    xi_d     = xi_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          op_d    = i_cmd_op;
          a_d     = i_cmd_a;
          b_d     = i_cmd_b;
          err_d   = 1'b0;
          xi_d    = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        err_d = data_err;
        if (i_HREADY) begin
          if (data_err) begin
            result_d = '0;
            state_d  = S_RESP;
          end else if (xi_q == 2'd3) begin
            result_d = i_HRDATA;
            state_d  = S_RESP;
          end else begin
            xi_d    = xi_q + 2'd1;
            state_d = S_ADDR;
          end
        end
      end
      default: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) begin
      state_q  <= S_IDLE;
      xi_q     <= 2'd0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xi_q     <= xi_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode only registered state, so AHB inputs never reach AHB outputs.
  always_comb begin
    o_HTRANS = HTRANS_IDLE;
    o_HADDR  = '0;
    o_HWRITE = 1'b0;
    o_HWDATA = '0;
    if (state_q == S_ADDR) begin
      o_HTRANS = HTRANS_NONSEQ;
      o_HADDR  = BASE_ADDR + xfer_offset(xi_q);
      o_HWRITE = (xi_q != 2'd3);
    end else if (state_q == S_DATA) begin
      case (xi_q)
        2'd0:    o_HWDATA = a_q;
        2'd1:    o_HWDATA = b_q;
        2'd2:    o_HWDATA = {28'b0, op_q};
        default: o_HWDATA = '0;
      endcase
    end
  end

  assign o_HSIZE     = HSIZE_WORD;
  assign o_HBURST    = HBURST_SINGLE;
  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_data  = result_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_riscv_alu_cmd_master.sv
// Bench for riscv_alu_cmd_master: an in-bench ALU slave with configurable waits and errors,
// directed cases plus randomized commands checked against a transaction-level model.
module tb_riscv_alu_cmd_master;
  import riscv_alu_cmd_master_pkg::*;

  localparam logic [31:0] BASE = 32'hE000_0000;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [3:0]         i_cmd_op;
  logic [31:0]        i_cmd_a;
  logic [31:0]        i_cmd_b;
  logic               o_rsp_valid;
  logic               i_rsp_ready;
  logic [31:0]        o_rsp_data;
  logic               o_rsp_err;
  logic [31:0]        i_HRDATA;
  logic [1:0]         i_HRESP;
  logic               i_HREADY;
  logic [31:0]        o_HADDR;
  logic [31:0]        o_HWDATA;
  logic               o_HWRITE;
  logic [2:0]         o_HSIZE;
  logic [W_BURST-1:0] o_HBURST;
  logic [1:0]         o_HTRANS;

  riscv_alu_cmd_master #(.BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .i_HRDATA(i_HRDATA), .i_HRESP(i_HRESP), .i_HREADY(i_HREADY),
    .o_HADDR(o_HADDR), .o_HWDATA(o_HWDATA), .o_HWRITE(o_HWRITE),
    .o_HSIZE(o_HSIZE), .o_HBURST(o_HBURST), .o_HTRANS(o_HTRANS)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave register file standing in for the ALU peripheral.
  logic [31:0] s_a, s_b;
  logic [3:0]  s_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // One command from handshake to response handshake. The bench plays the slave, one
  // decision per cycle at the negedge, and predicts transfers, data and response cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int wait_lo, input int wait_hi, input int astall_hi,
                         input int err_idx, input int rsp_delay, input bit garble);
    logic [31:0] exp_addr [4];
    logic [31:0] exp_wd [4];
    logic [31:0] exp_data, slave_addr;
    int n_xfers, cur, cyc, exp_cyc, astall_left, waits_left;
    bit in_data, is_err;

    exp_addr = '{BASE + OFF_A, BASE + OFF_B, BASE + OFF_OP, BASE + OFF_P};
    exp_wd   = '{a, b, {28'b0, op}, 32'd0};
    n_xfers  = (err_idx < 0) ? 4 : err_idx + 1;
    exp_data = (err_idx < 0) ? alu_ref(op, a, b) : 32'd0;

    check("idle_ready", {31'b0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    i_rsp_ready = 1'b0;
    step();

    cur = 0; cyc = 1; in_data = 1'b0; waits_left = 0; slave_addr = '0;
    astall_left = $urandom_range(astall_hi, 0);
    exp_cyc = 2 + astall_left;
    while (!o_rsp_valid) begin
      if (cyc > 300) begin
        check("rsp_timeout", 32'd0, 32'd1);
        i_cmd_valid = 1'b0;
        return;
      end
      i_cmd_valid = garble ? 1'($urandom_range(1, 0)) : 1'b0;
      i_cmd_op    = 4'($urandom);
      i_cmd_a     = $urandom;
      i_cmd_b     = $urandom;
      i_HREADY    = 1'b1;
      i_HRESP     = HRESP_OKAY;
      i_HRDATA    = $urandom;
      if (in_data) begin
        check("data_htrans", {30'b0, o_HTRANS}, {30'b0, HTRANS_IDLE});
        check("data_hwdata", o_HWDATA, exp_wd[cur]);
        is_err  = (cur == err_idx);
        i_HRESP = is_err ? HRESP_ERROR : HRESP_OKAY;
        if (waits_left > 0) begin
          i_HREADY = 1'b0;
          waits_left--;
        end else begin
          if (!is_err) begin
            case (slave_addr - BASE)
              OFF_A:   s_a  = o_HWDATA;
              OFF_B:   s_b  = o_HWDATA;
              OFF_OP:  s_op = o_HWDATA[3:0];
              default: i_HRDATA = alu_ref(s_op, s_a, s_b);
            endcase
          end
          in_data = 1'b0;
          cur++;
          if (cur < n_xfers) begin
            astall_left = $urandom_range(astall_hi, 0);
            exp_cyc += 1 + astall_left;
          end
        end
      end else if (o_HTRANS == HTRANS_NONSEQ) begin
        if (cur >= n_xfers) begin
          check("extra_xfer", cur, n_xfers);
        end else begin
          check("addr_haddr", o_HADDR, exp_addr[cur]);
          check("addr_hwrite", {31'b0, o_HWRITE}, (cur != 3) ? 32'd1 : 32'd0);
          if (astall_left > 0) begin
            i_HREADY = 1'b0;
            astall_left--;
          end else begin
            slave_addr = o_HADDR;
            in_data    = 1'b1;
            waits_left = $urandom_range(wait_hi, wait_lo);
            exp_cyc += 1 + waits_left;
          end
        end
      end else begin
        check("addr_htrans", {30'b0, o_HTRANS}, {30'b0, HTRANS_NONSEQ});
      end
      step();
      cyc++;
    end

    i_cmd_valid = 1'b0;
    i_HREADY    = 1'b1;
    i_HRESP     = HRESP_OKAY;
    check("xfer_count", cur, n_xfers);
    check("rsp_cycle", cyc, exp_cyc);
    check("rsp_data", o_rsp_data, exp_data);
    check("rsp_err", {31'b0, o_rsp_err}, (err_idx >= 0) ? 32'd1 : 32'd0);
    check("rsp_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
    repeat (rsp_delay) begin
      step();
      check("hold_valid", {31'b0, o_rsp_valid}, 32'd1);
      check("hold_data", o_rsp_data, exp_data);
      check("hold_htrans", {30'b0, o_HTRANS}, {30'b0, HTRANS_IDLE});
      check("hold_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("post_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
  endtask

  initial begin
    HRESET = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_a = '0; i_cmd_b = '0;
    i_rsp_ready = 1'b0; i_HRDATA = '0; i_HRESP = HRESP_OKAY; i_HREADY = 1'b1;
    s_a = '0; s_b = '0; s_op = '0;
    @(negedge HCLK);
    step();
    check("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_err", {31'b0, o_rsp_err}, 32'd0);
    check("rst_htrans", {30'b0, o_HTRANS}, 32'd0);
    check("rst_haddr", o_HADDR, 32'd0);
    check("rst_hwdata", o_HWDATA, 32'd0);
    check("rst_hwrite", {31'b0, o_HWRITE}, 32'd0);
    check("rst_hsize", {29'b0, o_HSIZE}, 32'd2);
    check("rst_hburst", {29'b0, o_HBURST}, 32'd0);
    HRESET = 1'b0;
    step();

    // Zero-wait SLT, then back-to-back ADD, 2 wait states, ERROR on B, stalled consumer.
    run_cmd(ALU_SLT, 32'd0, 32'd1, 0, 0, 0, -1, 0, 1'b0);
    run_cmd(ALU_ADD, 32'd8, 32'd6, 0, 0, 0, -1, 0, 1'b1);
    run_cmd(ALU_SUB, 32'd5, 32'd9, 2, 2, 0, -1, 0, 1'b0);
    run_cmd(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 1, 1, 0, 1, 0, 1'b0);
    run_cmd(ALU_OR, 32'h1234_0000, 32'h0000_5678, 0, 0, 0, -1, 5, 1'b1);
    run_cmd(ALU_SRA, 32'h8000_0000, 32'd4, 0, 0, 0, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(4'($urandom_range(ALU_SLTU, 0)), $urandom, $urandom,
              0, 2, 1, ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
              $urandom_range(3, 0), 1'b1);
    end

    // Reset during the OP write data phase (zero-wait: cycle 6 after handshake).
    i_cmd_valid = 1'b1; i_cmd_op = ALU_AND; i_cmd_a = 32'hFFFF_0000; i_cmd_b = 32'h00FF_FF00;
    step();
    i_cmd_valid = 1'b0;
    repeat (5) step();
    check("rstmid_hwdata", o_HWDATA, {28'b0, ALU_AND});
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("rstmid_htrans", {30'b0, o_HTRANS}, {30'b0, HTRANS_IDLE});
    check("rstmid_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
    check("rstmid_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rstmid_rsp_err", {31'b0, o_rsp_err}, 32'd0);
    repeat (3) step();
    check("rstmid_quiet", {30'b0, o_HTRANS}, {30'b0, HTRANS_IDLE});
    run_cmd(ALU_SLL, 32'd3, 32'd4, 0, 1, 1, -1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
